// File: rtl/fifo_read_drainer.sv
// fifo_read_drainer: reader-side master for a synchronous FIFO.
// Issues rd_en, captures the word one cycle later, and re-presents words on a
// valid/ready stream through a 2-entry output buffer. This keeps a 1 word/cycle
// stream going despite the FIFO's 1-cycle read latency.
// Also counts delivered words and latches any read that the FIFO reports as underflow.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | not issuing reads; buffered words still drain
// RUN   | issuing reads while enable is high and there is room
// STOP  | enable dropped with a read in flight; waits one cycle for it
module fifo_read_drainer #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  underflow_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  head_q, head_d;
  logic [FIFO_WIDTH-1:0] obuf_q [2];
  logic [FIFO_WIDTH-1:0] obuf_d [2];
  logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
  logic                  underflow_err_q, underflow_err_d;

  logic                  push;
  logic                  pop;
  logic                  room;
  logic                  tail;

  // A word landing with underflow is dropped. It is never pushed into the buffer.
  assign push = inflight_q & ~fifo_underflow;
  assign pop  = m_valid & m_ready;
  // Buffered words plus the word in flight must stay within the two buffer slots.
  assign room = ({1'b0, occ_q} + {2'b0, inflight_q}) < 3'd2;
  // When occ is 2, a push can only happen together with a pop. In that case the
  // freed head slot is the tail.
  assign tail = head_q ^ occ_q[0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. STOP lasts exactly one cycle because no read is issued in
  // the cycle that enters it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) state_d = inflight_q ? STOP : IDLE;
      end
      STOP: begin
        state_d = enable ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. rd_en is combinational from m_ready so that reads continue
  // back-to-back while the buffer is full but emptying.
  always_comb begin
    m_valid    = (occ_q != 2'd0);
    m_data     = m_valid ? obuf_q[head_q] : '0;
    fifo_rd_en = ~rst & (state_q == RUN) & enable & ~fifo_empty & (room | pop);
    busy       = (state_q != IDLE) | m_valid;
  end

  // Next values for the buffer, the in-flight tracking, the word counter and the error flag.
  always_comb begin
    obuf_d          = obuf_q;
    head_d          = head_q;
    occ_d           = occ_q;
    inflight_d      = fifo_rd_en;
    rd_count_d      = rd_count_q;
    underflow_err_d = underflow_err_q;

    if (push) begin
      obuf_d[tail] = fifo_data_out;
    end
    if (pop) begin
      head_d     = ~head_q;
      rd_count_d = rd_count_q + CNT_WIDTH'(pop);
    end
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};

    if (inflight_q && fifo_underflow) begin
      underflow_err_d = 1'b1;
    end
  end

  // Datapath registers. Reset drops buffered and in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q           <= 2'd0;
      inflight_q      <= 1'b0;
      head_q          <= 1'b0;
      obuf_q[0]       <= '0;
      obuf_q[1]       <= '0;
      rd_count_q      <= '0;
      underflow_err_q <= 1'b0;
    end else begin
      occ_q           <= occ_d;
      inflight_q      <= inflight_d;
      head_q          <= head_d;
      obuf_q[0]       <= obuf_d[0];
      obuf_q[1]       <= obuf_d[1];
      rd_count_q      <= rd_count_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  assign rd_count      = rd_count_q;
  assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_fifo_read_drainer.sv
// Testbench for fifo_read_drainer: a bench-side FIFO plus a queue-based reference
// model that is checked on every cycle, and directed scenarios with literal expectations.
module tb_fifo_read_drainer;
  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, enable, m_ready, uf_spur;
  logic          fifo_rd_en, fifo_empty, fifo_underflow, m_valid, underflow_err, busy;
  logic [W-1:0]  fifo_data_out, m_data;
  logic [CW-1:0] rd_count;
  logic          uf_reg;

  logic [W-1:0]  fifo_mem [0:4095];
  int            wr_cnt, rd_cnt, uf_word;
  int            n_pass, n_total, cyc;

  // reference model state
  int            m_state;      // 0 idle, 1 run, 2 stop
  logic [W-1:0]  mbuf [$];
  bit            minfl;
  int            mcount;
  bit            merr;
  bit            model_live;
  int            rd_pulses;
  logic [W-1:0]  log_d [$];
  int            log_c [$];

  always #5 clk = ~clk;

  fifo_read_drainer #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_rd_en(fifo_rd_en),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .rd_count(rd_count),
    .underflow_err(underflow_err), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
  endtask

  // bench FIFO: 1-cycle read latency; a marked word comes back flagged as underflow
  assign fifo_empty     = (rd_cnt == wr_cnt);
  assign fifo_underflow = uf_reg | uf_spur;
  initial begin rd_cnt = 0; uf_reg = 1'b0; fifo_data_out = '0; end
  always @(posedge clk) begin
    uf_reg <= 1'b0;
    if (fifo_rd_en) begin
      if (rd_cnt != wr_cnt) begin
        fifo_data_out <= fifo_mem[rd_cnt];
        if (rd_cnt == uf_word) uf_reg <= 1'b1;
        rd_cnt <= rd_cnt + 1;
      end else begin
        uf_reg <= 1'b1;
      end
    end
  end

  task automatic model_reset();
    m_state = 0;
    mbuf.delete();
    minfl = 1'b0;
    mcount = 0;
    merr = 1'b0;
  endtask

  // compare process: check outputs against the model, then advance the model one cycle
  always @(negedge clk) begin
    bit ev, er, pop;
    logic [W-1:0] ed;
    cyc++;
    if (model_live) begin
      ev = (mbuf.size() != 0);
      ed = ev ? mbuf[0] : '0;
      er = !rst && m_state == 1 && enable && !fifo_empty &&
           ((mbuf.size() + int'(minfl) < 2) || (ev && m_ready));
      chk("rd_en", {31'd0, fifo_rd_en}, {31'd0, er});
      chk("m_valid", {31'd0, m_valid}, {31'd0, ev});
      chk("m_data", 32'(m_data), 32'(ed));
      chk("rd_count", 32'(rd_count), mcount);
      chk("underflow_err", {31'd0, underflow_err}, {31'd0, merr});
      chk("busy", {31'd0, busy}, {31'd0, (m_state != 0) || ev});
      if (fifo_rd_en) rd_pulses++;
      pop = ev && m_ready;
      if (rst) begin
        model_reset();
      end else begin
        if (pop) begin
          log_d.push_back(ed);
          log_c.push_back(cyc);
          void'(mbuf.pop_front());
          mcount = (mcount + 1) % (1 << CW);
        end
        if (minfl) begin
          if (fifo_underflow) merr = 1'b1;
          else mbuf.push_back(fifo_data_out);
        end
        case (m_state)
          0: if (enable) m_state = 1;
          1: if (!enable) m_state = minfl ? 2 : 0;
          default: m_state = enable ? 1 : 0;
        endcase
        minfl = er;
      end
    end else if (rst) begin
      model_reset();
      model_live = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    if (wr_cnt < 4096) begin
      fifo_mem[wr_cnt] = d;
      wr_cnt++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int mark, p0, n;
    bit found;
    logic [W-1:0] v;
    n_pass = 0; n_total = 0; cyc = 0; model_live = 1'b0; rd_pulses = 0;
    rst = 1'b1; enable = 1'b1; m_ready = 1'b1; uf_spur = 1'b0;
    wr_cnt = 0; uf_word = -1;
    for (int i = 1; i <= 8; i++) push(W'(i));

    // T1: reset held with enable high and data waiting
    repeat (3) @(posedge clk);
    sample();
    chk("t1_rd_en", {31'd0, fifo_rd_en}, 0);
    chk("t1_m_valid", {31'd0, m_valid}, 0);
    chk("t1_rd_count", 32'(rd_count), 0);
    chk("t1_busy", {31'd0, busy}, 0);

    // T2: streaming 1..8
    step();
    mark = log_d.size(); p0 = rd_pulses;
    rst = 1'b0;
    repeat (14) step();
    sample();
    chk("t2_xfers", log_d.size() - mark, 8);
    if (log_d.size() >= mark + 8) begin
      for (int i = 0; i < 8; i++) chk("t2_data", 32'(log_d[mark+i]), i + 1);
      chk("t2_consecutive", log_c[mark+7] - log_c[mark], 7);
    end
    chk("t2_rd_pulses", rd_pulses - p0, 8);
    chk("t2_rd_count", 32'(rd_count), 8);
    chk("t2_rd_en_empty", {31'd0, fifo_rd_en}, 0);

    // T3: backpressure mid-stream
    step();
    for (int i = 9; i <= 16; i++) push(W'(i));
    repeat (3) step();
    m_ready = 1'b0;
    repeat (4) step();
    sample();
    chk("t3_hold_rd_en", {31'd0, fifo_rd_en}, 0);
    chk("t3_hold_valid", {31'd0, m_valid}, 1);
    chk("t3_hold_data", 32'(m_data), log_d.size() + 1);
    step();
    m_ready = 1'b1;
    repeat (15) step();
    sample();
    chk("t3_total", log_d.size(), 16);
    chk("t3_last", 32'(log_d[log_d.size()-1]), 16);
    chk("t3_rd_count_wrap", 32'(rd_count), 0);

    // T4: enable dropped the cycle after a read
    step();
    p0 = rd_pulses;
    m_ready = 1'b0;
    for (int i = 17; i <= 20; i++) push(W'(i));
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sample();
      if (fifo_rd_en) begin found = 1'b1; break; end
    end
    chk("t4_rd_seen", {31'd0, found}, 1);
    step();
    enable = 1'b0;
    sample();
    chk("t4_busy_run", {31'd0, busy}, 1);
    repeat (6) step();
    sample();
    chk("t4_one_read", rd_pulses - p0, 1);
    chk("t4_buffered", {31'd0, m_valid}, 1);
    step();
    m_ready = 1'b1;
    repeat (4) step();
    sample();
    chk("t4_idle", {31'd0, busy}, 0);
    chk("t4_last", 32'(log_d[log_d.size()-1]), 17);
    chk("t4_rd_count", 32'(rd_count), 1);

    // T5: underflow on the word at index 18 (value 19)
    step();
    mark = log_d.size();
    uf_word = 18;
    enable = 1'b1;
    repeat (10) step();
    sample();
    chk("t5_err", {31'd0, underflow_err}, 1);
    chk("t5_xfers", log_d.size() - mark, 2);
    if (log_d.size() >= mark + 2) begin
      chk("t5_word_a", 32'(log_d[mark]), 18);
      chk("t5_word_b", 32'(log_d[mark+1]), 20);
    end
    chk("t5_rd_count", 32'(rd_count), 3);
    repeat (5) step();
    sample();
    chk("t5_err_sticky", {31'd0, underflow_err}, 1);

    // T6: counter wrap after 17 words, then reset with a full buffer
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    chk("t6_err_clr", {31'd0, underflow_err}, 0);
    chk("t6_cnt_clr", 32'(rd_count), 0);
    step();
    mark = log_d.size();
    for (int i = 21; i <= 37; i++) push(W'(i));
    repeat (25) step();
    sample();
    chk("t6_xfers", log_d.size() - mark, 17);
    chk("t6_rd_count", 32'(rd_count), 1);
    step();
    m_ready = 1'b0;
    for (int i = 38; i <= 41; i++) push(W'(i));
    repeat (4) step();
    sample();
    chk("t6_full_valid", {31'd0, m_valid}, 1);
    chk("t6_full_rd_en", {31'd0, fifo_rd_en}, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    chk("t6_post_rst_valid", {31'd0, m_valid}, 0);
    chk("t6_post_rst_data", 32'(m_data), 0);
    step();
    m_ready = 1'b1;

    // random phase, checked by the model every cycle
    n = 0;
    repeat (3000) begin
      enable  = ($urandom % 8) != 0;
      m_ready = ($urandom % 4) != 0;
      if ($urandom % 2 == 1) begin
        v = W'($urandom);
        push(v);
      end
      if ($urandom % 64 == 0) uf_word = wr_cnt - 1;
      uf_spur = ($urandom % 40) == 0;
      rst     = ($urandom % 250) == 0;
      step();
      n++;
    end
    rst = 1'b0; uf_spur = 1'b0; enable = 1'b0; m_ready = 1'b1;
    repeat (10) step();
    sample();
    chk("final_idle", {31'd0, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
